// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the console UART transmit arbiter.
package mexiko_uart_pkg;

   localparam int UART_BYTE_W     = 8;
   localparam int DEFAULT_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transceiver bundle of the UART transmit arbiter.
// timeout_o exists only when MEXIKO_UART_ARB_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if
   import mexiko_uart_pkg::*;
#(
   parameter int NUM_REQ = 2
);
   localparam int IDX_W = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0]             req_valid_i;
   logic [UART_BYTE_W*NUM_REQ-1:0] req_data_i;
   logic [NUM_REQ-1:0]             req_last_i;
   logic [NUM_REQ-1:0]             req_ready_o;
   logic [UART_BYTE_W-1:0]         tx_data_o;
   logic                           tx_wr_o;
   logic                           tx_done_i;
   logic [IDX_W-1:0]               grant_o;
   logic                           locked_o;
   logic                           busy_o;
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
   logic                           timeout_o;
`endif

   modport master (
      output req_valid_i, req_data_i, req_last_i, tx_done_i,
      input  req_ready_o, tx_data_o, tx_wr_o, grant_o, locked_o, busy_o
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
      , input timeout_o
`endif
   );

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, tx_done_i,
      output req_ready_o, tx_data_o, tx_wr_o, grant_o, locked_o, busy_o
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
      , output timeout_o
`endif
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search; a held lock restricts the choice to the owner.
module uart_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               lock,
   input  logic [IDX_W-1:0]   owner,
   output logic [IDX_W-1:0]   winner,
   output logic               found
);

   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest so the nearest valid requester after ptr wins.
   always_comb begin
      winner = owner;
      found  = 1'b0;
      cand   = '0;
      if (lock) begin
         found = req[owner];
      end else begin
         for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
               winner = cand;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the console UART transmitter between NUM_REQ byte requesters with packet lock.
// Optional lock timeout: define MEXIKO_UART_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | looking for a byte to accept (owner only while locked)
// WR      | tx_wr_o pulse to the transceiver
// WAIT    | byte on the wire, waiting for tx_done_i
module uart_tx_arbiter
   import mexiko_uart_pkg::*;
#(
   parameter int NUM_REQ = 2
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
   , parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
   input logic              sys_clk_i,
   input logic              sys_rst_n_i,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_t             state_q, state_d;
   logic [UART_BYTE_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic                   locked_q, locked_d;
   logic [NUM_REQ-1:0]     ready;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_found;
   logic [UART_BYTE_W-1:0] pick_data;

`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
`endif

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (bus.req_valid_i),
      .ptr    (grant_q),
      .lock   (locked_q),
      .owner  (grant_q),
      .winner (pick_idx),
      .found  (pick_found)
   );

   assign pick_data = bus.req_data_i[UART_BYTE_W*int'(pick_idx) +: UART_BYTE_W];

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      grant_d  = grant_q;
      locked_d = locked_q;
      ready    = '0;
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               ready[pick_idx] = 1'b1;
               data_d          = pick_data;
               grant_d         = pick_idx;
               locked_d        = ~bus.req_last_i[pick_idx];
               state_d         = ST_WR;
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
               cnt_d           = TO_LOAD;
`endif
            end
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
            // Not found while locked means the owner has gone quiet.
            else if (locked_q) begin
               if (cnt_q == '0) begin
                  locked_d  = 1'b0;
                  timeout_d = 1'b1;
                  cnt_d     = TO_LOAD;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
`endif
         end
         ST_WR:   state_d = ST_WAIT;
         ST_WAIT: if (bus.tx_done_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         grant_q  <= IDX_W'(NUM_REQ - 1);
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         grant_q  <= grant_d;
         locked_q <= locked_d;
      end
   end

`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
   always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
      if (!sys_rst_n_i) begin
         cnt_q     <= TO_LOAD;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout_o = timeout_q;
`endif

   // ready is combinational from valid, so mask it while reset is held.
   assign bus.req_ready_o = sys_rst_n_i ? ready : '0;
   assign bus.tx_data_o   = data_q;
   assign bus.tx_wr_o     = (state_q == ST_WR);
   assign bus.grant_o     = grant_q;
   assign bus.locked_o    = locked_q;
   assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters.
module tb_uart_tx_arbiter;
   import mexiko_uart_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ (2)
`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
      , .TIMEOUT (16)
`endif
   ) dut (
      .sys_clk_i   (clk),
      .sys_rst_n_i (rst_n),
      .bus         (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic finish_byte(input int n);
      repeat (n) cycle();
      bus.tx_done_i = 1'b1;
      cycle();
      bus.tx_done_i = 1'b0;
   endtask

   task automatic expect_byte(input string tag, input logic [31:0] g, input logic [31:0] d);
      for (int i = 0; i < 20; i++) begin
         if (bus.tx_wr_o) break;
         cycle();
      end
      check({tag, "_wr"},    32'(bus.tx_wr_o), 32'd1);
      check({tag, "_grant"}, 32'(bus.grant_o), g);
      check({tag, "_data"},  32'(bus.tx_data_o), d);
   endtask

   initial begin
      // 1: reset behaviour
      bus.req_valid_i = 2'b11;
      bus.req_data_i  = {8'h52, 8'h41};
      bus.req_last_i  = 2'b11;
      bus.tx_done_i   = 1'b0;
      repeat (3) cycle();
      check("rst_ready",  32'(bus.req_ready_o), 32'd0);
      check("rst_data",   32'(bus.tx_data_o),   32'h00);
      check("rst_wr",     32'(bus.tx_wr_o),     32'd0);
      check("rst_grant",  32'(bus.grant_o),     32'd1);
      check("rst_locked", 32'(bus.locked_o),    32'd0);
      check("rst_busy",   32'(bus.busy_o),      32'd0);
      rst_n = 1'b1;
      #1;
      check("first_ready", 32'(bus.req_ready_o), 32'b01);
      cycle();
      check("first_wr",    32'(bus.tx_wr_o),     32'd1);
      check("first_data",  32'(bus.tx_data_o),   32'h41);
      check("first_grant", 32'(bus.grant_o),     32'd0);
      check("first_busy",  32'(bus.busy_o),      32'd1);
      check("wr_ready",    32'(bus.req_ready_o), 32'd0);
      cycle();
      check("wr_single",   32'(bus.tx_wr_o),     32'd0);
      check("wait_busy",   32'(bus.busy_o),      32'd1);
      finish_byte(9);

      // 2: round robin
      expect_byte("rr1", 32'd1, 32'h52);
      finish_byte(10);
      check("rr_ready", 32'(bus.req_ready_o), 32'b01);
      expect_byte("rr2", 32'd0, 32'h41);
      finish_byte(10);
      expect_byte("rr3", 32'd1, 32'h52);
      finish_byte(10);
      expect_byte("rr4", 32'd0, 32'h41);

      // 3: packet lock, "OK\n" from requester 1
      bus.req_data_i = {8'h4F, 8'h41};
      bus.req_last_i = 2'b01;
      finish_byte(10);
      expect_byte("pk_O", 32'd1, 32'h4F);
      check("pk_lock1", 32'(bus.locked_o), 32'd1);
      bus.req_valid_i = 2'b01;
      finish_byte(10);
      check("pk_idle_ready", 32'(bus.req_ready_o), 32'd0);
      repeat (5) begin
         cycle();
         check("pk_hold_ready", 32'(bus.req_ready_o), 32'd0);
         check("pk_hold_lock",  32'(bus.locked_o),    32'd1);
      end
      bus.req_valid_i = 2'b11;
      bus.req_data_i  = {8'h4B, 8'h41};
      #1;
      check("pk_owner_ready", 32'(bus.req_ready_o), 32'b10);
      expect_byte("pk_K", 32'd1, 32'h4B);
      check("pk_lock2", 32'(bus.locked_o), 32'd1);
      bus.req_data_i = {8'h0A, 8'h41};
      bus.req_last_i = 2'b11;
      finish_byte(10);
      expect_byte("pk_NL", 32'd1, 32'h0A);
      check("pk_unlock", 32'(bus.locked_o), 32'd0);
      bus.req_valid_i = 2'b01;
      finish_byte(10);
      expect_byte("pk_after", 32'd0, 32'h41);

      // 4: pacing; tx_done during WR is ignored
      bus.req_valid_i = 2'b11;
      bus.tx_done_i   = 1'b1;
      cycle();
      bus.tx_done_i   = 1'b0;
      check("pace_busy", 32'(bus.busy_o), 32'd1);
      repeat (100) begin
         check("pace_wr",    32'(bus.tx_wr_o),     32'd0);
         check("pace_ready", 32'(bus.req_ready_o), 32'd0);
         cycle();
      end
      bus.req_valid_i = 2'b00;
      bus.tx_done_i   = 1'b1;
      cycle();
      bus.tx_done_i   = 1'b0;
      check("pace_idle", 32'(bus.busy_o), 32'd0);
      bus.tx_done_i   = 1'b1;
      cycle();
      bus.tx_done_i   = 1'b0;
      check("spur_busy", 32'(bus.busy_o),    32'd0);
      check("spur_wr",   32'(bus.tx_wr_o),   32'd0);
      check("spur_data", 32'(bus.tx_data_o), 32'h41);

      // 5: reset in WAIT while locked
      bus.req_valid_i = 2'b11;
      bus.req_data_i  = {8'h4F, 8'h41};
      bus.req_last_i  = 2'b01;
      #1;
      check("mr_ready", 32'(bus.req_ready_o), 32'b10);
      expect_byte("mr_O", 32'd1, 32'h4F);
      cycle();
      check("mr_lock", 32'(bus.locked_o), 32'd1);
      check("mr_busy", 32'(bus.busy_o),   32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_rst_lock",  32'(bus.locked_o),    32'd0);
      check("mr_rst_busy",  32'(bus.busy_o),      32'd0);
      check("mr_rst_grant", 32'(bus.grant_o),     32'd1);
      check("mr_rst_data",  32'(bus.tx_data_o),   32'h00);
      check("mr_rst_ready", 32'(bus.req_ready_o), 32'd0);
      cycle();
      bus.req_data_i = {8'h52, 8'h41};
      bus.req_last_i = 2'b11;
      rst_n = 1'b1;
      #1;
      check("mr_rel_ready", 32'(bus.req_ready_o), 32'b01);
      expect_byte("mr_first", 32'd0, 32'h41);

`ifdef MEXIKO_UART_ARB_TIMEOUT_EN
      // 6: lock timeout, TIMEOUT=16
      bus.req_valid_i = 2'b01;
      bus.req_data_i  = {8'h66, 8'h55};
      bus.req_last_i  = 2'b10;
      finish_byte(10);
      expect_byte("to_lead", 32'd0, 32'h55);
      check("to_lock", 32'(bus.locked_o), 32'd1);
      bus.req_valid_i = 2'b10;
      finish_byte(10);
      repeat (16) begin
         check("to_wait_pulse", 32'(bus.timeout_o),   32'd0);
         check("to_wait_lock",  32'(bus.locked_o),    32'd1);
         check("to_wait_ready", 32'(bus.req_ready_o), 32'd0);
         cycle();
      end
      check("to_pulse", 32'(bus.timeout_o),   32'd1);
      check("to_drop",  32'(bus.locked_o),    32'd0);
      check("to_ready", 32'(bus.req_ready_o), 32'b10);
      cycle();
      check("to_pulse_end", 32'(bus.timeout_o), 32'd0);
      expect_byte("to_next", 32'd1, 32'h66);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single transmit side of the SoC console uart_transceiver between NUM_REQ byte requesters (for example the CPU console path and the debug/bench injector).
- Round-robin arbitration with packet lock: a requester that starts a line keeps the UART until it marks the last byte.
- Drives the transceiver's tx_data/tx_wr and paces on tx_done.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
IDX_W, $clog2(NUM_REQ) (min 1), grant index width (derived, localparam)
TIMEOUT, 4096, idle cycles before a held lock is dropped (used only with the optional feature)

Ports:
sys_clk_i  input  1  system clock
sys_rst_n_i  input  1  reset, asynchronous assert, active-low
req_valid_i  input  NUM_REQ  per-requester byte valid
req_data_i  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last_i  input  NUM_REQ  byte is the last of its packet
req_ready_o  output  NUM_REQ  byte accepted this cycle (one-hot or zero)
tx_data_o  output  8  to transceiver tx_data
tx_wr_o  output  1  to transceiver tx_wr, single-cycle pulse
tx_done_i  input  1  from transceiver tx_done
grant_o  output  IDX_W  index of the last/current owner
locked_o  output  1  packet lock held
busy_o  output  1  state != IDLE

Behaviour:
- Reset values: req_ready_o=0, tx_data_o=8'h00, tx_wr_o=0, grant_o=NUM_REQ-1, locked_o=0, busy_o=0. The round-robin pointer is reset to NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, WR, WAIT.
- IDLE behaviour:
  - Candidate selection: if locked, the only candidate is grant_o. Otherwise the winner is the first valid requester searching grant_o+1 ... grant_o+NUM_REQ, modulo NUM_REQ.
  - If a candidate is valid, req_ready_o[winner]=1 in the same cycle. This is combinational from req_valid_i; requesters must not make valid depend on ready.
  - On acceptance, register tx_data_o and grant_o, then go to WR.
  - locked_o is set to ~req_last_i[winner] on acceptance.
- WR: tx_wr_o=1 for exactly one cycle, then go to WAIT. tx_done_i is ignored in WR.
- WAIT: stay until tx_done_i=1, then go to IDLE. The next acceptance can occur in the cycle after tx_done_i.
- Latency: byte accepted in cycle N gives tx_wr_o high in cycle N+1. Minimum 3 cycles per byte excluding UART time.
- Unlocked requesters see req_ready_o=0 while the lock is held, however long the owner stays idle (without the optional feature).
- tx_data_o holds its value until the next acceptance.
- Simultaneous valid requests: exactly one is granted, in round-robin order. The pointer advances only on acceptance.
- A spurious tx_done_i in IDLE is ignored.
- Reset mid-operation: immediate return to reset values. Any partially sent UART byte is the transceiver's concern; the lock is dropped.

Optional Feature:
- Macro: MEXIKO_UART_ARB_TIMEOUT_EN
- With the macro defined:
  - A 16-bit counter increments each IDLE cycle while locked_o=1 and the owner's req_valid_i=0.
  - The counter clears on any acceptance.
  - On reaching TIMEOUT-1, locked_o clears next cycle and normal round-robin resumes.
  - An extra output timeout_o pulses for 1 cycle at the drop.
- Without the macro: no counter, no timeout_o port, and the lock is held indefinitely.

Decomposition:
- Package mexiko_uart_pkg holds:
  - the FSM state typedef (IDLE/WR/WAIT)
  - UART_BYTE_W=8
  - the default TIMEOUT
- Sub-module uart_rr_pick: combinational round-robin search.
  - Inputs: request vector, pointer, lock, owner.
  - Outputs: winner index, found flag.
- All state and registers live in uart_tx_arbiter.

Test Plan:
1. Reset behaviour: hold sys_rst_n_i=0 with req_valid_i=2'b11 -> all outputs at reset values. After release, requester 0 is accepted first with data 8'h41, and tx_wr_o pulses one cycle later with tx_data_o=8'h41.
2. Round-robin order: both requesters valid, last=1 on every byte, tx_done_i 10 cycles after each tx_wr_o -> grant order is 0,1,0,1 with no starvation.
3. Packet lock: requester 1 sends "OK\n" (8'h4F, 8'h4B, last on 8'h0A) while requester 0 is continuously valid -> bytes 4F, 4B, 0A go out contiguously before any requester 0 byte; locked_o=1 until 0A is accepted.
4. Pacing: after a tx_wr_o pulse, hold tx_done_i=0 for 100 cycles -> no req_ready_o and no second tx_wr_o during that time. tx_done_i in the WR cycle has no effect.
5. Mid-operation reset: assert reset in WAIT while locked -> locked_o=0 and busy_o=0 immediately. After release, requester 0 is served first.
6. Timeout (MEXIKO_UART_ARB_TIMEOUT_EN defined, TIMEOUT=16): requester 0 sends a byte with last=0, then goes idle -> after 16 idle cycles timeout_o pulses, locked_o=0, and requester 1 is accepted next.
